msg_scroll_display: RTL and testbench
=====================================

// Module: msg_scroll_display
// PURPOSE
//  Generalised per-state message generator for the multiplexed 7-seg display.
//  Holds a ROM of one string per machine state and scrolls strings longer than DIGITS.
//  Emits the 6-bit character code for the digit currently addressed by the refresh scanner.
//  Sits between the main FSM (cur_state) and the segment decoder.
// PARAMETERS
//  DIGITS   4  number of display digits, >=2
//  CODE_W   6  character code width (0-9 digits, 10-35 = A-Z, 36 = BLANK)
//  MAX_LEN  8  maximum string length held in the ROM
//  GAP      2  blank characters inserted between scroll repetitions
// PORTS
//  clk          in   1                    system clock
//  rst_n        in   1                    reset, synchronous, active-low
//  cur_state    in   4                    FSM state (WELCOME=0 GAME=1 SCORE=2 ERROR=3 COIN=4 PASS=5)
//  ref_sign     in   1                    refresh strobe, 1-cycle pulse
//  refresh      in   $clog2(DIGITS)       digit index; 0 = rightmost digit
//  scroll_tick  in   1                    scroll-step strobe, 1-cycle pulse
//  char_code    out  CODE_W               character for the addressed digit
//  msg_valid    out  1                    1 when cur_state has a ROM entry
//  wrap         out  1                    1-cycle pulse when scroll offset wraps to 0
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): char_code=36 (BLANK), msg_valid=0, wrap=0, offset=0,
//    stage-1 register=BLANK, state register=0. Reset mid-scroll aborts the scroll.
//  - ROM strings: 0 "HELLO", 1 "PLAY", 2 "SCORE", 3 "ERROR", 4 "COIN", 5 "PASS".
//    States 6-15 are invalid: msg_valid=0 and every digit shows BLANK.
//  - Position shown on digit d: p = offset + (DIGITS-1-d).
//    If p >= len, the digit shows BLANK.
//  - Scroll:
//    - Active only if len > DIGITS. Otherwise offset stays 0 and short strings are
//      left-justified with BLANK padding.
//    - Each scroll_tick: offset increments. At offset == len+GAP-1, the next tick sets
//      offset to 0 and wrap pulses in the following cycle.
//  - State change: registered state != cur_state -> offset=0 in the same edge.
//    This takes priority over a coincident scroll_tick, and wrap is not asserted.
//  - Pipeline:
//    - ref_sign at edge N latches the lookup into stage-1.
//    - char_code updates at edge N+1, giving a latency of 2 clocks from the ref_sign cycle.
//    - Without ref_sign, both stages hold.
//    - refresh >= DIGITS with ref_sign high: stage-1 holds its previous value.
//  - msg_valid is registered: 1 cycle after cur_state.
//  - Width rules: offset is $clog2(MAX_LEN+GAP) bits. p is computed 1 bit wider
//    to avoid overflow.
// CONFIGURATION
//  MSG_BLINK_EN defined:
//    - In ERROR state a blink flag toggles on every scroll_tick and clears on state change.
//    - While the flag is 1, char_code is forced to BLANK.
//    - ERROR ("ERROR", len 5) still scrolls normally underneath.
//  MSG_BLINK_EN undefined: no blink flag; ERROR behaves like every other state.
// STRUCTURE
//  - Package msg_pkg: state encodings, char codes (CH_0..CH_9, CH_A..CH_Z, CH_BLANK=36),
//    ROM contents, and a length table.
//  - Sub-module msg_rom: combinational (state, pos) -> code, plus len per state.
//  - Top level: offset counter, state-change detect, blink flag, 2-stage output pipe.
// TESTING
//  1. PASS state, offset 0; ref_sign with refresh 0,1,2,3 -> char_code 28,28,10,25,
//     each 2 clocks after its strobe.
//  2. WELCOME, 1 scroll_tick; refresh 3 -> 14 ('E'), refresh 0 -> 24 ('O').
//     Second tick -> refresh 0 = 36.
//  3. WELCOME scroll period = 7 ticks (5+GAP). wrap pulses exactly once after tick 7,
//     then refresh 3 -> 17 ('H').
//  4. WELCOME at offset 3; cur_state -> GAME in the same cycle as scroll_tick ->
//     offset 0, no wrap, refresh 3..0 -> 25,21,10,34.
//  5. cur_state=9 -> msg_valid=0, all digits 36. Assert rst_n=0 mid-scroll ->
//     char_code=36, offset 0 on the next edge.
//  6. MSG_BLINK_EN, ERROR state: alternate scroll_ticks -> char_code alternates 36 and the
//     scrolled character. Without the macro -> never forced to 36.

Source files
------------

// File: rtl/msg_scroll_display_pkg.sv
// Shared constants for the scrolling message display: state codes, character codes,
// per-state string ROM and length table.
package msg_pkg;
  localparam int CW       = 6;
  localparam int NUM_MSG  = 6;
  localparam int ROM_LEN  = 8;
  localparam int LEN_W    = 4;
  localparam int SEL_W    = 3;
  localparam int CH_IDX_W = 3;

  typedef logic [CW-1:0]    ch_t;
  typedef logic [LEN_W-1:0] len_t;

  typedef enum logic [3:0] {
    ST_WELCOME = 4'd0, ST_GAME = 4'd1, ST_SCORE = 4'd2,
    ST_ERROR   = 4'd3, ST_COIN = 4'd4, ST_PASS  = 4'd5
  } state_e;

  localparam ch_t CH_0 = 6'd0, CH_1 = 6'd1, CH_2 = 6'd2, CH_3 = 6'd3, CH_4 = 6'd4;
  localparam ch_t CH_5 = 6'd5, CH_6 = 6'd6, CH_7 = 6'd7, CH_8 = 6'd8, CH_9 = 6'd9;
  localparam ch_t CH_A = 6'd10, CH_B = 6'd11, CH_C = 6'd12, CH_D = 6'd13, CH_E = 6'd14;
  localparam ch_t CH_F = 6'd15, CH_G = 6'd16, CH_H = 6'd17, CH_I = 6'd18, CH_J = 6'd19;
  localparam ch_t CH_K = 6'd20, CH_L = 6'd21, CH_M = 6'd22, CH_N = 6'd23, CH_O = 6'd24;
  localparam ch_t CH_P = 6'd25, CH_Q = 6'd26, CH_R = 6'd27, CH_S = 6'd28, CH_T = 6'd29;
  localparam ch_t CH_U = 6'd30, CH_V = 6'd31, CH_W = 6'd32, CH_X = 6'd33, CH_Y = 6'd34;
  localparam ch_t CH_Z = 6'd35, CH_BLANK = 6'd36;

  localparam ch_t ROM [NUM_MSG][ROM_LEN] = '{
    '{CH_H, CH_E, CH_L, CH_L, CH_O, CH_BLANK, CH_BLANK, CH_BLANK},
    '{CH_P, CH_L, CH_A, CH_Y, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK},
    '{CH_S, CH_C, CH_O, CH_R, CH_E, CH_BLANK, CH_BLANK, CH_BLANK},
    '{CH_E, CH_R, CH_R, CH_O, CH_R, CH_BLANK, CH_BLANK, CH_BLANK},
    '{CH_C, CH_O, CH_I, CH_N, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK},
    '{CH_P, CH_A, CH_S, CH_S, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK}
  };

  localparam len_t LEN_TAB [NUM_MSG] = '{4'd5, 4'd4, 4'd5, 4'd5, 4'd4, 4'd4};
endpackage

// File: rtl/msg_scroll_display_if.sv
// Control/data bundle between the main FSM, refresh scanner and the message display.
interface msg_scroll_display_if #(
  parameter int DIGITS = 4,
  parameter int CODE_W = 6
);
  localparam int RW = $clog2(DIGITS);

  logic [3:0]        cur_state;
  logic              ref_sign;
  logic [RW-1:0]     refresh;
  logic              scroll_tick;
  logic [CODE_W-1:0] char_code;
  logic              msg_valid;
  logic              wrap;

  modport master (output cur_state, ref_sign, refresh, scroll_tick,
                  input  char_code, msg_valid, wrap);
  modport slave  (input  cur_state, ref_sign, refresh, scroll_tick,
                  output char_code, msg_valid, wrap);
endinterface

// File: rtl/msg_scroll_display_rom.sv
// Combinational string ROM: (state, position) -> character code, plus string length.
module msg_rom
  import msg_pkg::*;
#(
  parameter int PW = 5
) (
  input  logic [3:0]    state,
  input  logic [PW-1:0] pos,
  output ch_t           code,
  output len_t          len
);
  logic [SEL_W-1:0]    si;
  logic [CH_IDX_W-1:0] ci;

  always_comb begin
    si   = state[SEL_W-1:0];
    ci   = pos[CH_IDX_W-1:0];
    code = CH_BLANK;
    len  = '0;
    if (state < 4'(NUM_MSG)) begin
      len = LEN_TAB[si];
      if (pos < PW'(len)) code = ROM[si][ci];
    end
  end
endmodule

// File: rtl/msg_scroll_display.sv
// Per-state scrolling message generator feeding the 7-seg decoder.
// Optional MSG_BLINK_EN: blanks the display on alternate scroll ticks in ERROR.
module msg_scroll_display
  import msg_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int CODE_W  = 6,
  parameter int MAX_LEN = 8,
  parameter int GAP     = 2
) (
  input logic                clk,
  input logic                rst_n,
  msg_scroll_display_if.slave bus
);
  localparam int OFF_W = $clog2(MAX_LEN + GAP);
  localparam int PW    = OFF_W + 1;
  localparam int RW    = $clog2(DIGITS);
  localparam logic [CODE_W-1:0] BLANK = CODE_W'(CH_BLANK);

  logic [3:0]        st_q;
  logic [OFF_W-1:0]  offset;
  logic [OFF_W-1:0]  last;
  logic [PW-1:0]     pos;
  logic              s1_vld;
  logic [CODE_W-1:0] s1;
  logic [CODE_W-1:0] code_q;
  logic              valid_q;
  logic              wrap_q;
  ch_t               rom_code;
  len_t              len;
  logic              chg;
  logic              scrolls;
  logic              ref_ok;

  msg_rom #(.PW(PW)) u_rom (
    .state (st_q),
    .pos   (pos),
    .code  (rom_code),
    .len   (len)
  );

  always_comb begin
    chg     = (st_q != bus.cur_state);
    scrolls = (len > LEN_W'(DIGITS));
    last    = OFF_W'(len) + OFF_W'(GAP - 1);
    // Widened by one bit so offset + leftmost digit index cannot wrap.
    pos     = PW'(offset) + PW'(DIGITS - 1) - PW'(bus.refresh);
    ref_ok  = ({1'b0, bus.refresh} < (RW + 1)'(DIGITS));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= '0;
      offset  <= '0;
      wrap_q  <= 1'b0;
      valid_q <= 1'b0;
      s1_vld  <= 1'b0;
      s1      <= BLANK;
      code_q  <= BLANK;
    end else begin
      st_q    <= bus.cur_state;
      valid_q <= (bus.cur_state < 4'(NUM_MSG));
      wrap_q  <= 1'b0;
      s1_vld  <= bus.ref_sign;
      // A state change restarts the scroll and swallows a coincident tick.
      if (chg) begin
        offset <= '0;
      end else if (bus.scroll_tick && scrolls) begin
        if (offset == last) begin
          offset <= '0;
          wrap_q <= 1'b1;
        end else begin
          offset <= offset + OFF_W'(1);
        end
      end
      if (bus.ref_sign && ref_ok) s1 <= CODE_W'(rom_code);
      if (s1_vld) code_q <= s1;
    end
  end

`ifdef MSG_BLINK_EN
  logic blink;

  always_ff @(posedge clk) begin
    if (!rst_n)                                    blink <= 1'b0;
    else if (chg)                                  blink <= 1'b0;
    else if (st_q == ST_ERROR && bus.scroll_tick)  blink <= ~blink;
  end

  assign bus.char_code = blink ? BLANK : code_q;
`else
  assign bus.char_code = code_q;
`endif

  assign bus.msg_valid = valid_q;
  assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_msg_scroll_display.sv
// Scoreboard bench for msg_scroll_display: strobes push expected codes, a monitor
// compares them two clocks after each refresh strobe.
module tb_msg_scroll_display;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  msg_scroll_display_if #(.DIGITS(4), .CODE_W(6)) bus ();

  msg_scroll_display #(.DIGITS(4), .CODE_W(6), .MAX_LEN(8), .GAP(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [5:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   wraps  = 0;
  logic d1 = 1'b0;
  logic d2 = 1'b0;

`ifdef MSG_BLINK_EN
  localparam bit BL = 1'b1;
`else
  localparam bit BL = 1'b0;
`endif

  always @(posedge clk) begin
    d1 <= bus.ref_sign;
    d2 <= d1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus.wrap) wraps++;
    if (d2) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: char_code=%0d with no expected entry", bus.char_code);
      end else begin
        e = sb.pop_front();
        if (bus.char_code !== e.exp) begin
          errors++;
          $display("FAIL %s: char_code=%0d expected %0d", e.name, bus.char_code, e.exp);
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [1:0] r, input logic [5:0] exp, input string nm);
    exp_t e;
    e.name = nm;
    e.exp  = exp;
    bus.ref_sign = 1'b1;
    bus.refresh  = r;
    sb.push_back(e);
    cyc();
    bus.ref_sign = 1'b0;
  endtask

  task automatic tick();
    bus.scroll_tick = 1'b1;
    cyc();
    bus.scroll_tick = 1'b0;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) cyc();
    chk("sb_drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    bus.cur_state   = 4'd0;
    bus.ref_sign    = 1'b0;
    bus.refresh     = 2'd0;
    bus.scroll_tick = 1'b0;
    cyc(3);
    chk("rst_char", bus.char_code, 36);
    chk("rst_valid", bus.msg_valid, 0);
    chk("rst_wrap", bus.wrap, 0);
    rst_n = 1'b1;

    // PASS, short string: no scroll, left-justified
    bus.cur_state = 4'd5;
    cyc();
    chk("pass_valid", bus.msg_valid, 1);
    strobe(2'd0, 6'd28, "pass_d0");
    strobe(2'd1, 6'd28, "pass_d1");
    strobe(2'd2, 6'd10, "pass_d2");
    strobe(2'd3, 6'd25, "pass_d3");
    drain();
    bus.cur_state = 4'd0;
    cyc(3);
    chk("hold_no_strobe", bus.char_code, 25);

    // WELCOME scrolling
    strobe(2'd3, 6'd17, "hello_off0_d3");
    tick();
    strobe(2'd3, 6'd14, "hello_off1_d3");
    strobe(2'd0, 6'd24, "hello_off1_d0");
    tick();
    strobe(2'd0, 6'd36, "hello_off2_d0");
    strobe(2'd3, 6'd21, "hello_off2_d3");
    drain();

    // Wrap after 7 ticks in total
    base = wraps;
    repeat (4) tick();
    strobe(2'd3, 6'd36, "hello_gap_d3");
    strobe(2'd1, 6'd36, "hello_gap_d1");
    drain();
    chk("no_early_wrap", wraps - base, 0);
    tick();
    chk("wrap_pulse", bus.wrap, 1);
    cyc();
    chk("wrap_clear", bus.wrap, 0);
    chk("wrap_once", wraps - base, 1);
    strobe(2'd3, 6'd17, "hello_wrapped_d3");
    drain();

    // State change coincident with tick at offset 3
    repeat (3) tick();
    strobe(2'd3, 6'd21, "hello_off3_d3");
    drain();
    base = wraps;
    bus.cur_state   = 4'd1;
    bus.scroll_tick = 1'b1;
    cyc();
    bus.scroll_tick = 1'b0;
    chk("chg_no_wrap", bus.wrap, 0);
    strobe(2'd3, 6'd25, "play_d3");
    strobe(2'd2, 6'd21, "play_d2");
    strobe(2'd1, 6'd10, "play_d1");
    strobe(2'd0, 6'd34, "play_d0");
    tick();
    strobe(2'd3, 6'd25, "play_noscroll_d3");
    drain();
    chk("chg_wraps", wraps - base, 0);

    // Invalid state, then reset mid-scroll
    bus.cur_state = 4'd9;
    cyc();
    chk("inv_valid", bus.msg_valid, 0);
    for (int i = 0; i < 4; i++) strobe(2'(i), 6'd36, "inv_blank");
    bus.cur_state = 4'd0;
    cyc();
    chk("welcome_valid", bus.msg_valid, 1);
    tick();
    tick();
    strobe(2'd3, 6'd21, "pre_rst_d3");
    drain();
    rst_n = 1'b0;
    cyc();
    chk("midrst_char", bus.char_code, 36);
    chk("midrst_valid", bus.msg_valid, 0);
    rst_n = 1'b1;
    strobe(2'd3, 6'd17, "post_rst_d3");
    drain();

    // ERROR: blinks only with MSG_BLINK_EN
    bus.cur_state = 4'd3;
    cyc();
    strobe(2'd3, 6'd14, "err_off0_d3");
    tick();
    strobe(2'd3, BL ? 6'd36 : 6'd27, "err_off1_d3");
    tick();
    strobe(2'd2, 6'd24, "err_off2_d2");
    tick();
    strobe(2'd3, BL ? 6'd36 : 6'd24, "err_off3_d3");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
